// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types, constants and width helper for the sequential BCD-to-binary converter.
// The optional invalid-digit check is enabled with the BCD_CHECK_EN macro (see bcd_to_bin_seq).
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest width that can hold 10**digits - 1, i.e. ceil(log2(10**digits)).
    function automatic int bin_width(input int digits);
        longint unsigned p;
        int              w;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        w = 32'sd0;
        for (int k = 0; k < 64; k++) begin
            if ((64'd1 << k) < p) begin
                w = k + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Operand/result handshake bundle between the keypad digit buffer, the converter and the ALU.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// Combinational acc*10 + d step, built from shifts so no multiplier is inferred.
module mul10_add #(
    parameter int W = 18
) (
    input  logic [W-1:0] i_acc,
    input  logic [3:0]   i_d,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_d_ext;

    assign w_d_ext = {{(W-4){1'b0}}, i_d};
    assign o_sum   = (i_acc << 3) + (i_acc << 1) + w_d_ext;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, valid/ready on both sides.
// Define BCD_CHECK_EN to build the sticky invalid-digit (>9) flag; otherwise err is tied low.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_to_bin_seq_if.slave bus
);

    localparam int         ACC_W    = OUT_W + 4;
    localparam logic [3:0] CNT_INIT = 4'(DIGITS);

    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
        $error("bcd_to_bin_seq: DIGITS must be in 1..8");
    end
    if (OUT_W < bin_width(DIGITS)) begin : g_bad_out_w
        $error("bcd_to_bin_seq: OUT_W too narrow for DIGITS");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_next;
    logic [3:0]          r_cnt;
    logic [4*DIGITS-1:0] r_shift;
    logic [OUT_W-1:0]    r_bin;
    logic                r_err;
    logic                r_in_ready;
    logic                r_out_valid;
    bcd_digit_t          w_digit;
    logic                w_digit_bad;

    assign w_digit = r_shift[4*DIGITS-1 -: 4];

    mul10_add #(.W(ACC_W)) u_mul10_add (
        .i_acc (r_acc),
        .i_d   (w_digit),
        .o_sum (w_acc_next)
    );

`ifdef BCD_CHECK_EN
    assign w_digit_bad = (w_digit > BCD_MAX);
`else
    assign w_digit_bad = 1'b0;
`endif

    // Next-state decode for the IDLE -> RUN -> DONE handshake sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs; reset aborts any conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= 4'd0;
            r_shift     <= '0;
            r_bin       <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift <= bus.bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_err   <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt - 4'd1;
                    r_err   <= r_err | w_digit_bad;
                    if (r_cnt == 4'd1) begin
                        r_bin <= w_acc_next[OUT_W-1:0];
                    end
                end
                DONE: begin
                    r_bin <= r_bin;
                end
                default: begin
                    r_acc <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bin_out   = r_bin;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, directed corner cases and random operands.
module tb_bcd_to_bin_seq;

`ifdef BCD_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.DIGITS(4), .OUT_W(14)) bus4 ();
    bcd_to_bin_seq_if #(.DIGITS(1), .OUT_W(4))  bus1 ();
    bcd_to_bin_seq_if #(.DIGITS(2), .OUT_W(7))  bus2 ();

    bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    bcd_to_bin_seq #(.DIGITS(1), .OUT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    bcd_to_bin_seq #(.DIGITS(2), .OUT_W(7))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: positional weights of the raw digits, reduced to OUT_W bits.
    function automatic void ref_conv(input logic [15:0] bcd, output logic [13:0] bin, output logic e);
        longint v;
        longint weight;
        v = 0;
        weight = 1;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] tmp;
            tmp = bcd >> (4 * i);
            v = v + longint'(tmp[3:0]) * weight;
            weight = weight * 10;
            if (tmp[3:0] > 4'd9) e = ERR_EN;
        end
        bin = 14'(v % 16384);
    endfunction

    // Starts just after a negedge; returns result, flags and edges from accept to out_valid.
    task automatic convert4(input logic [15:0] bcd, input int stall,
                            output logic [13:0] bin, output logic e, output logic ov, output int lat);
        bus4.bcd_in   = bcd;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
        end
        bin = bus4.bin_out;
        e   = bus4.err;
        ov  = bus4.out_valid;
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask

    initial begin
        logic [13:0] bin, exp_bin;
        logic        e, exp_e, ov;
        int          lat, seen;
        logic [15:0] rb;

        vecs[0] = '{16'h1234, 14'd1234, 1'b0};
        vecs[1] = '{16'h0000, 14'd0,    1'b0};
        vecs[2] = '{16'h9999, 14'd9999, 1'b0};
        vecs[3] = '{16'h0042, 14'd42,   1'b0};
        vecs[4] = '{16'h12A4, 14'd1304, ERR_EN};
        vecs[5] = '{16'h0042, 14'd42,   1'b0};
        vecs[6] = '{16'h8001, 14'd8001, 1'b0};

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.bcd_in = 16'h0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.bcd_in = 4'h0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.bcd_in = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready",  64'(bus4.in_ready),  64'd1);
        chk("reset_out_valid", 64'(bus4.out_valid), 64'd0);
        chk("reset_bin_out",   64'(bus4.bin_out),   64'd0);
        chk("reset_err",       64'(bus4.err),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("vec%0d_in_ready", i), 64'(bus4.in_ready), 64'd1);
            convert4(vecs[i].bcd, i % 3, bin, e, ov, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd5);
            chk($sformatf("vec%0d_out_valid", i), 64'(ov), 64'd1);
            chk($sformatf("vec%0d_bin", i), 64'(bin), 64'(vecs[i].bin));
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].err));
        end

        // Back-pressure in DONE with a competing in_valid
        bus4.bcd_in = 16'h0321; bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        chk("hold_enter_done", 64'(bus4.out_valid), 64'd1);
        bus4.bcd_in = 16'h0555; bus4.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 64'(bus4.out_valid), 64'd1);
            chk("hold_bin",       64'(bus4.bin_out),   64'd321);
            chk("hold_in_ready",  64'(bus4.in_ready),  64'd0);
        end
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        chk("release_in_ready",  64'(bus4.in_ready),  64'd1);
        chk("release_out_valid", 64'(bus4.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("late_accept_in_ready", 64'(bus4.in_ready), 64'd0);
        lat = 1;
        while (!bus4.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("late_accept_latency", 64'(lat), 64'd5);
        chk("late_accept_bin", 64'(bus4.bin_out), 64'd555);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;

        // Reset during the second RUN edge
        bus4.bcd_in = 16'h5678; bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", 64'(bus4.in_ready), 64'd1);
        chk("abort_bin",      64'(bus4.bin_out),  64'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        convert4(16'h0007, 0, bin, e, ov, lat);
        chk("after_abort_latency", 64'(lat), 64'd5);
        chk("after_abort_bin",     64'(bin), 64'd7);

        // Narrow instances: one and two digits
        bus1.bcd_in = 4'h9;  bus1.in_valid = 1'b1;
        bus2.bcd_in = 8'h99; bus2.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
        chk("d1_not_yet", 64'(bus1.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("d1_out_valid", 64'(bus1.out_valid), 64'd1);
        chk("d1_bin",       64'(bus1.bin_out),   64'd9);
        chk("d2_not_yet",   64'(bus2.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("d2_out_valid", 64'(bus2.out_valid), 64'd1);
        chk("d2_bin",       64'(bus2.bin_out),   64'd99);
        bus1.out_ready = 1'b1; bus2.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.out_ready = 1'b0; bus2.out_ready = 1'b0;
        chk("d1_idle", 64'(bus1.in_ready), 64'd1);
        chk("d2_idle", 64'(bus2.in_ready), 64'd1);

        // Random operands against the reference model
        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < 4; d++) begin
                rb[4*d +: 4] = (n % 5 == 4) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
            ref_conv(rb, exp_bin, exp_e);
            convert4(rb, int'($urandom_range(0, 3)), bin, e, ov, lat);
            chk($sformatf("rnd_%h_latency", rb), 64'(lat), 64'd5);
            chk($sformatf("rnd_%h_bin", rb),     64'(bin), 64'(exp_bin));
            chk($sformatf("rnd_%h_err", rb),     64'(e),   64'(exp_e));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
